// File: rtl/core_pkg.sv
// Shared writeback types: register index, write request payload and the
// source tag registered alongside each register file write.
package core_pkg;

  localparam int XLEN = 64;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LD
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Load response queue: a power-of-two deep FIFO of writeback requests.
// The caller never pushes when full or pops when empty.
module wb_fifo
  import core_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  wb_req_t       data_i,
  input  logic          pop_i,
  output wb_req_t       head_o,
  output logic [CW-1:0] count_o
);

  wb_req_t       mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PW'(1);
      if (pop_i)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results with queued load responses into one
// registered register file write per cycle and tracks pending loads.
module wb_arbiter
  import core_pkg::*;
#(
  parameter int LDQ_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  reg_idx_t        alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  reg_idx_t        ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            iss_ld_valid,
  input  reg_idx_t        iss_ld_rd,
  output logic            rd_we,
  output reg_idx_t        rd,
  output logic [XLEN-1:0] rd_data,
  output logic [31:0]     busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int CW = $clog2(LDQ_DEPTH + 1);

  logic [CW-1:0]   count;
  wb_req_t         head;
  wb_req_t         pushReq;
  logic            qEmpty, forceLd, aluWin, push, pop;
  logic [SW-1:0]   starve_q, starve_d;
  logic            rdWe_q, rdWe_d;
  reg_idx_t        rd_q, rd_d;
  logic [XLEN-1:0] rdData_q, rdData_d;
  wb_src_e         src_q, src_d;
  logic [31:0]     busy_q, busy_d;

  assign pushReq = '{rd: ld_rd, data: ld_data};

  wb_fifo #(.DEPTH(LDQ_DEPTH)) u_ldq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (pushReq),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

  // A load that has waited STARVE_MAX ALU wins at the head takes the slot.
  always_comb begin
    qEmpty    = (count == '0);
    forceLd   = !qEmpty && (starve_q == SW'(STARVE_MAX));
    alu_ready = !forceLd;
    ld_ready  = (count < CW'(LDQ_DEPTH));
    push      = ld_valid && ld_ready;
    aluWin    = alu_valid && alu_ready && (alu_rd != '0);
    pop       = !qEmpty && !aluWin;

    starve_d = '0;
    if (!qEmpty && aluWin)
      starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);

    rdWe_d   = 1'b0;
    rd_d     = rd_q;
    rdData_d = rdData_q;
    src_d    = WB_NONE;
    if (aluWin) begin
      rdWe_d   = 1'b1;
      rd_d     = alu_rd;
      rdData_d = alu_data;
      src_d    = WB_ALU;
    end else if (pop && (head.rd != '0)) begin
      rdWe_d   = 1'b1;
      rd_d     = head.rd;
      rdData_d = head.data;
      src_d    = WB_LD;
    end
  end

  // The clear is visible in the cycle the load write is presented; a new
  // issue to the same register in that cycle keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (rdWe_q && (src_q == WB_LD)) busy_d[rd_q] = 1'b0;
    if (iss_ld_valid && (iss_ld_rd != '0)) busy_d[iss_ld_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign busy = busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      rdWe_q   <= 1'b0;
      rd_q     <= '0;
      rdData_q <= '0;
      src_q    <= WB_NONE;
      busy_q   <= '0;
    end else begin
      starve_q <= starve_d;
      rdWe_q   <= rdWe_d;
      rd_q     <= rd_d;
      rdData_q <= rdData_d;
      src_q    <= src_d;
      busy_q   <= busy_d;
    end
  end

  assign rd_we   = rdWe_q;
  assign rd      = rd_q;
  assign rd_data = rdData_q;

endmodule
